adc_seq_ctrl: RTL and testbench
===============================

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per ADC bit period; SHALL be even and >=2.
REQ-002 Parameter CONV_PERIOD, default 16: bit periods per conversion frame; SHALL be >= DATA_W+4.
REQ-003 Parameter NUM_CH, default 8: channel count, 1..8.
REQ-004 Parameter DATA_W, default 12: sample width.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  run conversions while high.
REQ-008 ch_mask  in  NUM_CH  channels included in round-robin scan.
REQ-009 adc_convst  out  1  start-conversion pulse to ADC.
REQ-010 adc_sck  out  1  free-of-glitch registered serial clock.
REQ-011 adc_sdi  out  1  serial config word to ADC.
REQ-012 adc_sdo  in  1  serial conversion data from ADC.
REQ-013 sample_data  out  DATA_W  last completed sample.
REQ-014 sample_ch  out  3  channel of sample_data.
REQ-015 sample_valid / sample_ready  out / in  1  output handshake.
REQ-016 overrun  out  1  one-cycle pulse when an unaccepted sample is overwritten.

Function
REQ-017 Bit tick SHALL assert once every CLK_DIV clk cycles; all frame timing SHALL advance only on ticks.
REQ-018 FSM states IDLE, CONV, GAP, SHIFT, WAIT; frame bit index b = 0..CONV_PERIOD-1.
REQ-019 IDLE -> CONV at next tick when enable=1 and ch_mask!=0; otherwise remain IDLE.
REQ-020 CONV spans b=0,1 with adc_convst=1; GAP spans b=2; SHIFT spans b=3..DATA_W+2; WAIT spans remaining bits.
REQ-021 In SHIFT, adc_sck SHALL be low for the first CLK_DIV/2 cycles and high for the last CLK_DIV/2 cycles of each bit; adc_sck SHALL be 0 outside SHIFT.
REQ-022 adc_sdi SHALL change only at bit start; first 6 SHIFT bits SHALL carry, MSB first, {1, ch[0], ch[2], ch[1], 1, 0} for the next channel; adc_sdi=0 otherwise.
REQ-023 adc_sdo SHALL be captured MSB first on the clk where adc_sck rises.
REQ-024 Data returned in frame N SHALL belong to the channel programmed in frame N-1; the first frame after IDLE SHALL produce no sample.
REQ-025 Next channel SHALL be the lowest set ch_mask bit above the current channel, wrapping to the lowest set bit; ch_mask is sampled at each CONV entry.
REQ-026 At end of SHIFT, sample_data/sample_ch SHALL load and sample_valid SHALL assert on the following clk.
REQ-027 sample_valid SHALL clear on the clk where sample_valid && sample_ready.
REQ-028 A new sample arriving while sample_valid=1 and sample_ready=0 SHALL overwrite and pulse overrun for one clk.
REQ-029 enable or ch_mask falling to 0 mid-frame: current frame SHALL complete, including its sample; then IDLE.
REQ-030 At end of WAIT, go to CONV if run conditions hold, else IDLE.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, all outputs 0, counters 0 and channel pointer to channel 0.

Configuration
REQ-032 With ADC_SEQ_TIMESTAMP_EN defined, add output sample_ts[15:0], a frame counter incremented at each CONV entry and latched with each sample; without it, no port and no logic.

Structure
REQ-033 Shared package adc_pkg SHALL hold FSM state encoding, config-word bit positions and the GAP/CONV bit-count constants.
REQ-034 Sub-module adc_bit_tick (divider producing tick and sck phase) SHALL be separate.

Verification (CLK_DIV=2, CONV_PERIOD=16, NUM_CH=4, DATA_W=12)
REQ-035 Reset asserted mid-SHIFT -> all outputs 0 on the same cycle; adc_sck low.
REQ-036 enable=1, mask=4'b0001, model returns 12'hA5C -> convst high 4 clk, frame 32 clk, sdi word 6'b100010, second frame gives sample_valid, data A5C, ch 0.
REQ-037 mask=4'b1010 -> sdi programs 1,3,1,3; sample_ch sequence 1,3,1.
REQ-038 sample_ready=0 across two samples -> one overrun pulse, sample_data equals the second sample.
REQ-039 enable=1, mask=0 -> no convst; enable dropped mid-SHIFT -> frame finishes, sample delivered, IDLE.
REQ-040 With ADC_SEQ_TIMESTAMP_EN, successive samples show sample_ts incrementing by 1.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sequencer: FSM encoding, frame bit counts,
// config-word layout and channel selection helpers.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_GAP   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WAIT  = 3'd4
    } adc_state_e;

    localparam int CONV_BITS = 2;
    localparam int GAP_BITS  = 1;
    localparam int CFG_BITS  = 6;

    // Config word bit positions; bit 5 leaves the DUT first.
    localparam int CFG_START_POS = 5;
    localparam int CFG_CH0_POS   = 4;
    localparam int CFG_CH2_POS   = 3;
    localparam int CFG_CH1_POS   = 2;
    localparam int CFG_ONE_POS   = 1;
    localparam int CFG_ZERO_POS  = 0;

    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
        logic [CFG_BITS-1:0] w;
        w                = '0;
        w[CFG_START_POS] = 1'b1;
        w[CFG_CH0_POS]   = ch[0];
        w[CFG_CH2_POS]   = ch[2];
        w[CFG_CH1_POS]   = ch[1];
        w[CFG_ONE_POS]   = 1'b1;
        w[CFG_ZERO_POS]  = 1'b0;
        return w;
    endfunction

    // Lowest set mask bit above cur, else the lowest set bit overall.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] nxt;
        nxt = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) nxt = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) nxt = 3'(i);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/adc_bit_tick.sv
// Bit-period divider: tick marks the last clk of each bit period, sck_hi_nxt
// says whether the coming cycle falls in the high half of the bit.
module adc_bit_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick,
    output logic sck_hi_nxt
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick       = (cnt_q == '0);
        cnt_d      = tick ? CW'(CLK_DIV - 1) : (cnt_q - 1'b1);
        sck_hi_nxt = (cnt_d < CW'(CLK_DIV / 2));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Round-robin ADC conversion sequencer with serial config/readback and a
// valid/ready sample port. Define ADC_SEQ_TIMESTAMP_EN to add sample_ts.
//
// state    | meaning
// IDLE     | waiting for enable with a non-empty channel mask
// CONV     | convst high, bits 0..1 of the frame
// GAP      | bit 2, ADC settles before shifting
// SHIFT    | bits 3..DATA_W+2, sck toggles, config out / data in
// WAIT     | remaining frame bits, then next frame or IDLE
module adc_seq_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int CONV_PERIOD = 16,
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              adc_convst,
    output logic              adc_sck,
    output logic              adc_sdi,
    input  logic              adc_sdo,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
`ifdef ADC_SEQ_TIMESTAMP_EN
    ,
    output logic [15:0]       sample_ts
`endif
);

    localparam int BW          = $clog2(CONV_PERIOD);
    localparam int SHIFT_FIRST = CONV_BITS + GAP_BITS;
    localparam int SHIFT_LAST  = SHIFT_FIRST + DATA_W - 1;

    logic tick;
    logic sck_hi_nxt;

    adc_bit_tick #(.CLK_DIV(CLK_DIV)) u_bit_tick (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .sck_hi_nxt (sck_hi_nxt)
    );

    adc_state_e        state_q, state_d;
    logic [BW-1:0]     b_q, b_d;
    logic [2:0]        ch_ptr_q, ch_ptr_d;
    logic [2:0]        prev_ch_q, prev_ch_d;
    logic              have_prev_q, have_prev_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              convst_q, convst_d;
    logic              sck_q, sck_d;
    logic              sdi_q, sdi_d;
    logic [DATA_W-1:0] sample_data_q, sample_data_d;
    logic [2:0]        sample_ch_q, sample_ch_d;
    logic              sample_valid_q, sample_valid_d;
    logic              overrun_q, overrun_d;
    logic              load_smp;
    logic [7:0]        mask8;
    logic [CFG_BITS-1:0] cfg_w;
    logic              run;

    always_comb begin
        mask8              = '0;
        mask8[NUM_CH-1:0]  = ch_mask;
        run                = enable && (|ch_mask);
    end

    always_comb begin
        state_d        = state_q;
        b_d            = b_q;
        ch_ptr_d       = ch_ptr_q;
        prev_ch_d      = prev_ch_q;
        have_prev_d    = have_prev_q;
        shift_d        = shift_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = sample_valid_q && !sample_ready;
        overrun_d      = 1'b0;
        load_smp       = 1'b0;
        sdi_d          = 1'b0;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d     = ST_CONV;
                        b_d         = '0;
                        ch_ptr_d    = next_ch(ch_ptr_q, mask8);
                        have_prev_d = 1'b0;
                    end
                end
                ST_CONV: begin
                    b_d = b_q + 1'b1;
                    if (b_q == BW'(CONV_BITS - 1)) state_d = ST_GAP;
                end
                ST_GAP: begin
                    b_d = b_q + 1'b1;
                    if (b_q == BW'(SHIFT_FIRST - 1)) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    b_d = b_q + 1'b1;
                    if (b_q == BW'(SHIFT_LAST)) begin
                        state_d  = ST_WAIT;
                        load_smp = have_prev_q;
                    end
                end
                ST_WAIT: begin
                    if (b_q == BW'(CONV_PERIOD - 1)) begin
                        b_d = '0;
                        if (run) begin
                            state_d     = ST_CONV;
                            prev_ch_d   = ch_ptr_q;
                            ch_ptr_d    = next_ch(ch_ptr_q, mask8);
                            have_prev_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    b_d     = '0;
                end
            endcase
        end

        // Serial outputs are computed from next-state so they come straight off flops.
        convst_d = (state_d == ST_CONV);
        sck_d    = (state_d == ST_SHIFT) && sck_hi_nxt;
        cfg_w    = cfg_word(ch_ptr_d);
        if (state_d == ST_SHIFT) begin
            for (int k = 0; k < CFG_BITS; k++) begin
                if (b_d == BW'(SHIFT_FIRST + k)) sdi_d = cfg_w[CFG_BITS-1-k];
            end
        end

        if (sck_d && !sck_q) shift_d = {shift_q[DATA_W-2:0], adc_sdo};

        if (load_smp) begin
            sample_data_d  = shift_q;
            sample_ch_d    = prev_ch_q;
            sample_valid_d = 1'b1;
            overrun_d      = sample_valid_q && !sample_ready;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            b_q            <= '0;
            ch_ptr_q       <= '0;
            prev_ch_q      <= '0;
            have_prev_q    <= 1'b0;
            shift_q        <= '0;
            convst_q       <= 1'b0;
            sck_q          <= 1'b0;
            sdi_q          <= 1'b0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            b_q            <= b_d;
            ch_ptr_q       <= ch_ptr_d;
            prev_ch_q      <= prev_ch_d;
            have_prev_q    <= have_prev_d;
            shift_q        <= shift_d;
            convst_q       <= convst_d;
            sck_q          <= sck_d;
            sdi_q          <= sdi_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef ADC_SEQ_TIMESTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] sample_ts_q, sample_ts_d;

    always_comb begin
        ts_cnt_d    = ts_cnt_q;
        sample_ts_d = sample_ts_q;
        if ((state_d == ST_CONV) && (state_q != ST_CONV)) ts_cnt_d = ts_cnt_q + 16'd1;
        if (load_smp) sample_ts_d = ts_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q    <= '0;
            sample_ts_q <= '0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            sample_ts_q <= sample_ts_d;
        end
    end

    assign sample_ts = sample_ts_q;
`endif

    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl with a behavioural serial ADC model.
module tb_adc_seq_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int CONV_PERIOD = 16;
    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  ch_mask = 4'd0;
    logic        sample_ready = 1'b0;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid, overrun;
`ifdef ADC_SEQ_TIMESTAMP_EN
    logic [15:0] sample_ts;
    logic        ts_chk = 1'b0;
    logic        ts_have = 1'b0;
    logic [15:0] last_ts = 16'd0;
`endif

    always #5 clk = ~clk;

    adc_seq_ctrl #(
        .CLK_DIV(CLK_DIV), .CONV_PERIOD(CONV_PERIOD), .NUM_CH(NUM_CH), .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .adc_convst   (adc_convst),
        .adc_sck      (adc_sck),
        .adc_sdi      (adc_sdi),
        .adc_sdo      (adc_sdo),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
`ifdef ADC_SEQ_TIMESTAMP_EN
        ,
        .sample_ts    (sample_ts)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [14:0] exp_q[$];
    logic [5:0]  sdi_words[$];
    logic [11:0] data_tab [4] = '{12'hA5C, 12'h3C1, 12'h5AA, 12'h7E3};

    // ADC model: returns data for the channel decoded in the previous frame.
    logic [11:0] sr = 12'd0;
    logic [2:0]  model_ch = 3'd0;
    logic [5:0]  wbuf = 6'd0;
    int          wbits = 0;
    assign adc_sdo = sr[11];

    always @(negedge adc_convst) sr = data_tab[model_ch[1:0]];
    always @(negedge adc_sck)    sr = {sr[10:0], 1'b0};
    always @(posedge adc_convst) wbits = 0;
    always @(posedge adc_sck) begin
        if (wbits < 6) begin
            wbuf = {wbuf[4:0], adc_sdi};
            wbits++;
            if (wbits == 6) begin
                sdi_words.push_back(wbuf);
                model_ch = {wbuf[3], wbuf[2], wbuf[4]};
            end
        end
    end

    int   cyc = 0, conv_rises = 0, last_rise_cyc = 0, conv_len = 0;
    int   last_width = 0, last_period = 0, ovr_cnt = 0;
    logic conv_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (adc_convst) begin
            conv_len++;
        end else begin
            if (conv_prev) last_width = conv_len;
            conv_len = 0;
        end
        if (adc_convst && !conv_prev) begin
            conv_rises++;
            last_period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
        end
        conv_prev = adc_convst;
        if (overrun) ovr_cnt++;
    end

    // Scoreboard monitor: compares each accepted sample with the queue head.
    always @(negedge clk) begin
        logic [14:0] e;
        if (reset_n && sample_valid && sample_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sample_unexpected: got ch=%0d data=%h, none expected", sample_ch, sample_data);
            end else begin
                e = exp_q.pop_front();
                if ({sample_ch, sample_data} !== e) begin
                    bad++;
                    $display("FAIL sample: got ch=%0d data=%h, expected ch=%0d data=%h",
                             sample_ch, sample_data, e[14:12], e[11:0]);
                end
            end
`ifdef ADC_SEQ_TIMESTAMP_EN
            if (ts_chk) begin
                if (ts_have) begin
                    total++;
                    if (sample_ts !== last_ts + 16'd1) begin
                        bad++;
                        $display("FAIL sample_ts_step: got %0d expected %0d", sample_ts, last_ts + 16'd1);
                    end
                end
                ts_have = 1'b1;
                last_ts = sample_ts;
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        ch_mask = 4'd0;
        cycles(3);
        exp_q.delete();
        sdi_words.delete();
        reset_n = 1'b1;
        cycles(1);
    endtask

    task automatic wait_rises(input int target, input string nm);
        int n;
        n = 0;
        while (conv_rises < target && n < 400) begin
            cycles(1);
            n++;
        end
        if (conv_rises < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got rises=%0d expected %0d", nm, conv_rises, target);
        end
    endtask

    task automatic wait_sck_high(input string nm);
        int n;
        n = 0;
        while (!adc_sck && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!adc_sck) begin
            total++;
            bad++;
            $display("FAIL %s_sck_timeout: got sck=%0d expected 1", nm, adc_sck);
        end
    endtask

    initial begin
        int base;
        int obase;

        // Outputs held at zero while in reset.
        cycles(2);
        chk("reset_outs", {12'd0, adc_convst, adc_sck, adc_sdi, sample_valid, overrun, sample_ch, sample_data}, 32'd0);

        // Single channel 0: timing, config word and one sample.
        do_reset();
        sample_ready = 1'b1;
        exp_q.push_back({3'd0, 12'hA5C});
        base = conv_rises;
        enable = 1'b1;
        ch_mask = 4'b0001;
        wait_rises(base + 2, "t1");
        chk("convst_width", last_width, 4);
        chk("frame_period", last_period, 32);
        enable = 1'b0;
        cycles(80);
        chk("t1_rises", conv_rises, base + 2);
        chk("t1_queue", exp_q.size(), 0);
        chk("t1_words", sdi_words.size(), 2);
        if (sdi_words.size() > 0) chk("t1_sdi_word", sdi_words[0], 6'b100010);

        // Mask 1010: channels 1,3,1,3 programmed; samples 1,3,1.
        do_reset();
        sample_ready = 1'b1;
        exp_q.push_back({3'd1, 12'h3C1});
        exp_q.push_back({3'd3, 12'h7E3});
        exp_q.push_back({3'd1, 12'h3C1});
`ifdef ADC_SEQ_TIMESTAMP_EN
        ts_chk = 1'b1;
        ts_have = 1'b0;
`endif
        base = conv_rises;
        enable = 1'b1;
        ch_mask = 4'b1010;
        wait_rises(base + 4, "t2");
        enable = 1'b0;
        cycles(80);
`ifdef ADC_SEQ_TIMESTAMP_EN
        ts_chk = 1'b0;
`endif
        chk("t2_rises", conv_rises, base + 4);
        chk("t2_queue", exp_q.size(), 0);
        chk("t2_words", sdi_words.size(), 4);
        for (int i = 0; i < 4 && i < sdi_words.size(); i++)
            chk($sformatf("t2_sdi_word%0d", i), sdi_words[i], (i % 2 == 0) ? 6'b110010 : 6'b110110);

        // Overrun: two samples (ch1 then ch0) with ready low.
        do_reset();
        sample_ready = 1'b0;
        exp_q.push_back({3'd0, 12'hA5C});
        obase = ovr_cnt;
        base = conv_rises;
        enable = 1'b1;
        ch_mask = 4'b0011;
        wait_rises(base + 3, "t3");
        enable = 1'b0;
        cycles(80);
        chk("overrun_pulses", ovr_cnt - obase, 1);
        chk("t3_valid_held", sample_valid, 1);
        chk("t3_data_held", sample_data, 12'hA5C);
        sample_ready = 1'b1;
        cycles(3);
        chk("t3_queue", exp_q.size(), 0);
        chk("t3_valid_clr", sample_valid, 0);

        // Empty mask never converts; enable dropped mid-SHIFT still delivers.
        do_reset();
        sample_ready = 1'b1;
        base = conv_rises;
        enable = 1'b1;
        ch_mask = 4'b0000;
        cycles(100);
        chk("mask0_no_convst", conv_rises, base);
        exp_q.push_back({3'd0, 12'hA5C});
        ch_mask = 4'b0001;
        wait_rises(base + 2, "t4");
        wait_sck_high("t4");
        #1;
        enable = 1'b0;
        cycles(80);
        chk("t4_rises", conv_rises, base + 2);
        chk("t4_queue", exp_q.size(), 0);

        // Reset mid-SHIFT clears outputs immediately.
        do_reset();
        enable = 1'b1;
        ch_mask = 4'b0001;
        base = conv_rises;
        wait_rises(base + 1, "t5");
        wait_sck_high("t5");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {12'd0, adc_convst, adc_sck, adc_sdi, sample_valid, overrun, sample_ch, sample_data}, 32'd0);
        cycles(2);
        enable = 1'b0;
        reset_n = 1'b1;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
